// File: rtl/sigma_delta_pkg.sv
// Shared definitions for the sigma-delta serializer slice: FSM encoding,
// idle-pattern reset level and a counter-width helper.
package sigma_delta_pkg;

    localparam logic [0:0] SD_IDLE = 1'b0;
    localparam logic [0:0] SD_RUN  = 1'b1;

    // sdOut level after reset; the first starved en edge toggles it to 1.
    localparam logic SD_IDLE_RESET_BIT = 1'b0;

    function automatic int unsigned cntWidth(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sigma_delta_serializer_if.sv
// Word handshake between a sigma-delta word producer and the serializer.
interface sigma_delta_serializer_if #(
    parameter int OUTLEN = 16
);
    logic              inValid;
    logic [OUTLEN-1:0] inWord;
    logic              inReady;

    modport master (output inValid, output inWord, input inReady);
    modport slave  (input inValid, input inWord, output inReady);
endinterface

// File: rtl/sd_word_fifo.sv
// Small word FIFO with registered occupancy count; full/empty come straight
// from the count so push and pop decisions never see same-edge writes.
module sd_word_fifo
    import sigma_delta_pkg::*;
#(
    parameter int OUTLEN = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [OUTLEN-1:0] pushData_i,
    input  logic              pop_i,
    output logic [OUTLEN-1:0] popData_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PW = cntWidth(DEPTH);
    localparam int CW = cntWidth(DEPTH + 1);

    logic [OUTLEN-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wrPtr_q, wrPtr_d;
    logic [PW-1:0]     rdPtr_q, rdPtr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              doPush;
    logic              doPop;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign doPush    = push_i && !full_o;
    assign doPop     = pop_i && !empty_o;
    assign popData_o = mem_q[rdPtr_q];

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + PW'(1);
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + PW'(1);
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/sigma_delta_serializer.sv
// Replays buffered parallel sigma-delta words as a 1-bit stream, LSB first,
// one bit per en strobe; emits a toggling mid-scale pattern when starved.
module sigma_delta_serializer
    import sigma_delta_pkg::*;
#(
    parameter int OUTLEN = 16,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    sigma_delta_serializer_if.slave  inBus,
    output logic                     sdOut,
    output logic                     wordStart,
    output logic                     underrun
);

    localparam int BW = cntWidth(OUTLEN);
    localparam logic [BW-1:0] LAST_BIT = BW'(OUTLEN - 1);

    logic [0:0]        state_q, state_d;
    logic [BW-1:0]     bitCnt_q, bitCnt_d;
    logic [OUTLEN-1:0] shReg_q, shReg_d;
    logic              sdOut_q, sdOut_d;
    logic              wordStart_q, wordStart_d;
    logic              underrun_q, underrun_d;

    logic [OUTLEN-1:0] headWord;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              pop;
    logic              boundary;
    logic [BW-1:0]     nextCnt;

    sd_word_fifo #(
        .OUTLEN (OUTLEN),
        .DEPTH  (DEPTH)
    ) uFifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (inBus.inValid),
        .pushData_i (inBus.inWord),
        .pop_i      (pop),
        .popData_o  (headWord),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    assign inBus.inReady = !fifoFull;
    assign boundary      = en && ((state_q == SD_IDLE) || (bitCnt_q == LAST_BIT));
    assign nextCnt       = bitCnt_q + BW'(1);

    // At a word boundary either load the FIFO head or fall back to toggling;
    // an underrun is only reported when a word just ran out.
    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        shReg_d     = shReg_q;
        sdOut_d     = sdOut_q;
        wordStart_d = 1'b0;
        underrun_d  = 1'b0;
        pop         = 1'b0;
        if (boundary) begin
            bitCnt_d = '0;
            if (!fifoEmpty) begin
                shReg_d     = headWord;
                sdOut_d     = headWord[0];
                pop         = 1'b1;
                state_d     = SD_RUN;
                wordStart_d = 1'b1;
            end else begin
                sdOut_d    = ~sdOut_q;
                state_d    = SD_IDLE;
                underrun_d = (state_q == SD_RUN);
            end
        end else if (en && (state_q == SD_RUN)) begin
            bitCnt_d = nextCnt;
            sdOut_d  = shReg_q[nextCnt];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SD_IDLE;
            bitCnt_q    <= '0;
            shReg_q     <= '0;
            sdOut_q     <= SD_IDLE_RESET_BIT;
            wordStart_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            shReg_q     <= shReg_d;
            sdOut_q     <= sdOut_d;
            wordStart_q <= wordStart_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sdOut     = sdOut_q;
    assign wordStart = wordStart_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_sigma_delta_serializer.sv
// Self-checking bench for sigma_delta_serializer: constant vector table,
// hand-written corner sequences and randomized traffic against a bit-queue model.
module tb_sigma_delta_serializer;

    localparam int OUTLEN = 16;
    localparam int DEPTH  = 2;

    typedef struct {
        bit              en;
        bit              inValid;
        logic [OUTLEN-1:0] inWord;
        bit              expSd;
        bit              expWs;
        bit              expUr;
        bit              expRdy;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic sdOut, wordStart, underrun;

    sigma_delta_serializer_if #(.OUTLEN(OUTLEN)) bus ();

    sigma_delta_serializer #(
        .OUTLEN (OUTLEN),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .inBus     (bus),
        .sdOut     (sdOut),
        .wordStart (wordStart),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int errors  = 0;
    int checks  = 0;
    int wsCount = 0;
    int urCount = 0;

    // Reference model: pending words, and the not-yet-emitted bits of the
    // word currently on the wire.
    logic [OUTLEN-1:0] mFifo[$];
    bit                mBits[$];
    bit                mSd;
    bit                mRun;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mFifo.delete();
        mBits.delete();
        mSd  = 1'b0;
        mRun = 1'b0;
    endtask

    task automatic doReset(input string tag);
        rst         = 1'b0;
        en          = 1'b0;
        bus.inValid = 1'b0;
        bus.inWord  = '0;
        @(posedge clk);
        #1;
        checkOutput({tag, ".rstSd"},  sdOut,       0);
        checkOutput({tag, ".rstWs"},  wordStart,   0);
        checkOutput({tag, ".rstUr"},  underrun,    0);
        checkOutput({tag, ".rstRdy"}, bus.inReady, 1);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        wsCount = 0;
        urCount = 0;
    endtask

    task automatic applyStimulus(input bit e, input bit v, input logic [OUTLEN-1:0] w, input string tag);
        bit                ws;
        bit                ur;
        bit                preReady;
        logic [OUTLEN-1:0] head;
        en          = e;
        bus.inValid = v;
        bus.inWord  = w;
        preReady    = (mFifo.size() < DEPTH);
        ws          = 1'b0;
        ur          = 1'b0;
        if (e) begin
            if (mBits.size() == 0) begin
                if (mFifo.size() > 0) begin
                    head = mFifo.pop_front();
                    for (int i = 0; i < OUTLEN; i++) mBits.push_back(head[i]);
                    mSd  = mBits.pop_front();
                    ws   = 1'b1;
                    mRun = 1'b1;
                end else begin
                    mSd  = ~mSd;
                    ur   = mRun;
                    mRun = 1'b0;
                end
            end else begin
                mSd = mBits.pop_front();
            end
        end
        if (v && preReady) mFifo.push_back(w);
        @(posedge clk);
        #1;
        if (wordStart === 1'b1) wsCount++;
        if (underrun === 1'b1) urCount++;
        checkOutput({tag, ".sdOut"},     sdOut,       mSd);
        checkOutput({tag, ".wordStart"}, wordStart,   ws);
        checkOutput({tag, ".underrun"},  underrun,    ur);
        checkOutput({tag, ".inReady"},   bus.inReady, (mFifo.size() < DEPTH));
    endtask

    task automatic addVec(input bit e, input bit v, input logic [OUTLEN-1:0] w,
                          input bit sd, input bit ws, input bit ur, input bit rdy);
        vec_t t;
        t.en = e; t.inValid = v; t.inWord = w;
        t.expSd = sd; t.expWs = ws; t.expUr = ur; t.expRdy = rdy;
        vecs.push_back(t);
    endtask

    initial begin
        logic [OUTLEN-1:0] pat;
        bus.inValid = 1'b0;
        bus.inWord  = '0;

        // Idle toggling from reset, then 16'h00F1 played LSB first, then underrun.
        pat = 16'h00F1;
        addVec(1, 0, 0, 1, 0, 0, 1);
        addVec(1, 0, 0, 0, 0, 0, 1);
        addVec(1, 0, 0, 1, 0, 0, 1);
        addVec(1, 0, 0, 0, 0, 0, 1);
        addVec(0, 1, pat, 0, 0, 0, 1);
        for (int i = 0; i < OUTLEN; i++) addVec(1, 0, 0, pat[i], (i == 0), 0, 1);
        addVec(1, 0, 0, 1, 0, 1, 1);
        addVec(1, 0, 0, 0, 0, 0, 1);
        addVec(1, 0, 0, 1, 0, 0, 1);
        addVec(0, 0, 0, 1, 0, 0, 1);

        doReset("table");
        for (int i = 0; i < vecs.size(); i++) begin
            en          = vecs[i].en;
            bus.inValid = vecs[i].inValid;
            bus.inWord  = vecs[i].inWord;
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d.sdOut", i),     sdOut,       vecs[i].expSd);
            checkOutput($sformatf("vec%0d.wordStart", i), wordStart,   vecs[i].expWs);
            checkOutput($sformatf("vec%0d.underrun", i),  underrun,    vecs[i].expUr);
            checkOutput($sformatf("vec%0d.inReady", i),   bus.inReady, vecs[i].expRdy);
        end

        // Three back-to-back words: third stalls until the first pop.
        doReset("t3");
        applyStimulus(0, 1, 16'hFFFF, "t3.push0");
        applyStimulus(0, 1, 16'h0000, "t3.push1");
        bus.inWord = 16'hAAAA;
        checkOutput("t3.stall", bus.inReady, 0);
        applyStimulus(1, 1, 16'hAAAA, "t3.blocked");
        applyStimulus(1, 1, 16'hAAAA, "t3.push2");
        for (int i = 0; i < 3 * OUTLEN + 2; i++) applyStimulus(1, 0, 0, "t3.run");
        checkOutput("t3.wordStarts", wsCount, 3);
        checkOutput("t3.underruns",  urCount, 1);

        // Sustained rate: en every 4th cycle, one word every 64 cycles.
        doReset("t4");
        for (int c = 0; c < 64 * 6; c++) begin
            applyStimulus((c % 4) == 3, (c % 64) == 0, OUTLEN'($urandom), "t4");
        end
        checkOutput("t4.underruns",  urCount, 0);
        checkOutput("t4.wordStarts", wsCount, 6);

        // Asynchronous reset in the middle of a word with one word still queued.
        doReset("t5");
        applyStimulus(0, 1, 16'h1234, "t5.push0");
        applyStimulus(0, 1, 16'hBEEF, "t5.push1");
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, "t5.run");
        #2;
        rst = 1'b0;
        #1;
        checkOutput("t5.asyncSd",  sdOut,       0);
        checkOutput("t5.asyncRdy", bus.inReady, 1);
        checkOutput("t5.asyncWs",  wordStart,   0);
        checkOutput("t5.asyncUr",  underrun,    0);
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        wsCount = 0;
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, "t5.idle");
        checkOutput("t5.noStale", wsCount, 0);

        // Randomized traffic against the model.
        doReset("rnd");
        for (int c = 0; c < 1500; c++) begin
            applyStimulus($urandom_range(0, 1) == 1, ($urandom % 3) == 0, OUTLEN'($urandom), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
